// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file blocks: default widths and the
// reader FSM state encoding.
package regfile_pkg;

  localparam int unsigned W1_DEF = 2;
  localparam int unsigned W2_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SEND  = 2'd2
  } rf_state_t;

endpackage

// File: rtl/regfile_reader_if.sv
// Output word stream of the register-file reader. Optional out_par is present
// only when REGFILE_READER_PARITY_EN is defined.
//
// Handshake: a word transfers on a rising edge where out_valid=1 and
// out_ready=1; while out_valid=1 and out_ready=0 the source holds out_data,
// out_addr (and out_par) stable; out_valid never drops without a transfer
// except on abort or reset.
interface regfile_reader_if #(
  parameter int w1 = 2,
  parameter int w2 = 8
);
  logic [w2-1:0] out_data;
  logic [w1-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;
`ifdef REGFILE_READER_PARITY_EN
  logic          out_par;

  modport master (
    output out_data, out_addr, out_valid, out_par,
    input  out_ready
  );
  modport slave (
    input  out_data, out_addr, out_valid, out_par,
    output out_ready
  );
`else
  modport master (
    output out_data, out_addr, out_valid,
    input  out_ready
  );
  modport slave (
    input  out_data, out_addr, out_valid,
    output out_ready
  );
`endif
endinterface

// File: rtl/regfile_reader.sv
// Scans every register of an external register file and streams (addr, data)
// words out. Optional parity output enabled by REGFILE_READER_PARITY_EN.
module regfile_reader
  import regfile_pkg::*;
#(
  parameter int w1 = W1_DEF,
  parameter int w2 = W2_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic [w1-1:0]        sel,
  input  logic [w2-1:0]        o,
  output logic                 busy,
  output logic                 done,
  output rf_state_t            state_dbg,
  regfile_reader_if.master     stream
);

  localparam logic [w1-1:0] last_sel = '1;

  rf_state_t state;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      sel              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      stream.out_data  <= '0;
      stream.out_addr  <= '0;
      stream.out_valid <= 1'b0;
`ifdef REGFILE_READER_PARITY_EN
      stream.out_par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // sel keeps its last value here; abort vetoes a simultaneous start
          if (start && !abort) begin
            sel   <= '0;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (abort) begin
            busy             <= 1'b0;
            stream.out_valid <= 1'b0;
            state            <= IDLE;
          end else begin
            stream.out_data  <= o;
            stream.out_addr  <= sel;
            stream.out_valid <= 1'b1;
`ifdef REGFILE_READER_PARITY_EN
            stream.out_par   <= ^o;
`endif
            state            <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            busy             <= 1'b0;
            stream.out_valid <= 1'b0;
            state            <= IDLE;
          end else if (stream.out_ready) begin
            stream.out_valid <= 1'b0;
            if (sel == last_sel) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              sel   <= sel + w1'(1);
              state <= SETUP;
            end
          end
        end
        default: begin
          busy             <= 1'b0;
          stream.out_valid <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_reader.sv
// Directed self-checking bench for regfile_reader (w1=2, w2=8) with a small
// behavioural register file driving o from sel.
module tb_regfile_reader;
  import regfile_pkg::*;

  localparam int W = 10;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [1:0] sel;
  logic [7:0] o;
  logic       busy, done;
  rf_state_t  state_dbg;
  logic [7:0] rf [4];

  regfile_reader_if #(.w1(2), .w2(8)) bus ();

  regfile_reader #(.w1(2), .w2(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .sel       (sel),
    .o         (o),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .stream    (bus)
  );

  assign o = rf[sel];

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int extra  = 0;
  int dones  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: record what transfers at this edge, then sample 1 ns after it.
  task automatic step();
    logic         acc;
    logic [W-1:0] word;
    acc  = bus.out_valid && bus.out_ready && !abort && !rst;
    word = {bus.out_addr, bus.out_data};
    @(posedge clk);
    #1;
    if (acc === 1'b1) begin
      if (exp_q.size() > 0) check("word", word, exp_q.pop_front());
      else extra++;
    end
    if (done === 1'b1) dones++;
  endtask

  task automatic run_to_done(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      step();
      n++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic push_scan();
    for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), rf[i]});
  endtask

  task automatic new_test();
    exp_q.delete();
    extra = 0;
    dones = 0;
  endtask

  task automatic end_test(input string tag, input int exp_dones);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_extra_words"}, extra, 0);
    check({tag, "_done_count"}, dones, exp_dones);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, state_dbg, IDLE);
    check({tag, "_sel"}, sel, 0);
    check({tag, "_data"}, bus.out_data, 0);
    check({tag, "_addr"}, bus.out_addr, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
`ifdef REGFILE_READER_PARITY_EN
    check({tag, "_par"}, bus.out_par, 0);
`endif
  endtask

  int n;
  int k;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; bus.out_ready = 1'b0;
    rf[0] = 8'h01; rf[1] = 8'h02; rf[2] = 8'h04; rf[3] = 8'h08;
    step(); step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // abort together with start leaves the block idle
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_state", state_dbg, IDLE);
    check("start_abort_busy", busy, 0);

    // full scan with out_ready held high
    new_test(); push_scan();
    bus.out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_state", state_dbg, SETUP);
    check("t1_sel", sel, 0);
    step();
    check("t1_first_valid", bus.out_valid, 1);
    check("t1_first_addr", bus.out_addr, 0);
    check("t1_first_data", bus.out_data, 8'h01);
    step();
    check("t1_gap_valid", bus.out_valid, 0);
    run_to_done(20, n);
    check("t1_done_cycle", n + 2, 8);
    check("t1_busy_at_done", busy, 0);
    check("t1_valid_at_done", bus.out_valid, 0);
    step();
    check("t1_done_pulse", done, 0);
    check("t1_sel_retained", sel, 3);
    end_test("t1", 1);

    // stall at addr 1 for 5 cycles
    new_test(); push_scan();
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_stall_valid", bus.out_valid, 1);
      check("t2_stall_data", bus.out_data, 8'h02);
      check("t2_stall_addr", bus.out_addr, 1);
    end
    check("t2_stall_state", state_dbg, SEND);
    bus.out_ready = 1'b1;
    run_to_done(20, n);
    check("t2_resume_done", n, 5);
    end_test("t2", 1);

    // abort while addr 2 is offered with out_ready high
    new_test();
    exp_q.push_back({2'd0, 8'h01});
    exp_q.push_back({2'd1, 8'h02});
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("t3_pre_abort_addr", bus.out_addr, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t3_busy", busy, 0);
    check("t3_valid", bus.out_valid, 0);
    check("t3_state", state_dbg, IDLE);
    repeat (6) step();
    end_test("t3", 0);

    // start re-pulsed mid-scan is ignored
    new_test(); push_scan();
    start = 1'b1;
    step();
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      start = (i == 2 || i == 3 || i == 6);
      step();
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
    start = 1'b0;
    check("t4_done_cycle", k, 8);
    repeat (3) step();
    end_test("t4", 1);

    // reset in SETUP of addr 1, then a clean scan from addr 0
    new_test();
    exp_q.push_back({2'd0, 8'h01});
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("t5_pre_rst_state", state_dbg, SETUP);
    check("t5_pre_rst_sel", sel, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("t5_rst");
    end_test("t5a", 0);
    new_test(); push_scan();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done(20, n);
    check("t5_rescan_done", n, 8);
    end_test("t5b", 1);

`ifdef REGFILE_READER_PARITY_EN
    new_test();
    rf[0] = 8'h07; rf[1] = 8'h03;
    push_scan();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t6_par_07", bus.out_par, 1);
    step(); step();
    check("t6_addr1", bus.out_addr, 1);
    check("t6_par_03", bus.out_par, 0);
    run_to_done(20, n);
    end_test("t6", 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 SHALL have parameter w1, default 2, meaning register-file address width (2**w1 registers).
REQ-002 SHALL have parameter w2, default 8, meaning register-file data width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to read out all registers.
REQ-006 SHALL have port abort  input  1  terminate a scan in progress.
REQ-007 SHALL have port sel  output  w1  read select driven to the register file.
REQ-008 SHALL have port o  input  w2  register-file read data, combinational from sel.
REQ-009 SHALL have port out_data  output  w2  captured word.
REQ-010 SHALL have port out_addr  output  w1  index of the word in out_data.
REQ-011 SHALL have port out_valid  output  1  out_data/out_addr valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-013 SHALL have port busy  output  1  scan in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-015 SHALL implement the FSM IDLE, SETUP, SEND.
REQ-016 IDLE: on start=1, SHALL set sel=0 and busy=1, then go to SETUP; start in SETUP/SEND SHALL be ignored.
REQ-017 SETUP (exactly 1 cycle, lets o settle): SHALL register out_data=o and out_addr=sel, set out_valid=1, then go to SEND.
REQ-018 SEND: out_data/out_addr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 SEND with out_ready=1 and sel<2**w1-1: SHALL clear out_valid, increment sel, and return to SETUP.
REQ-020 SEND with out_ready=1 and sel=2**w1-1: SHALL clear out_valid and busy, pulse done for 1 cycle, and go to IDLE; sel SHALL NOT wrap.
REQ-021 Throughput: with out_ready held 1, a word SHALL be produced every 2 cycles, a full scan taking 2*2**w1 cycles from start to done.
REQ-022 abort=1 in SETUP or SEND SHALL go to IDLE at the next edge with out_valid=0, busy=0, done=0; abort SHALL take priority over out_ready in the same cycle.
REQ-023 abort=1 and start=1 together in IDLE SHALL leave the block in IDLE.
REQ-024 sel SHALL retain its last value in IDLE.

Reset
REQ-025 rst=1 at a rising edge SHALL force state=IDLE, sel=0, out_data=0, out_addr=0, out_valid=0, busy=0, done=0, and SHALL take priority over start/abort/out_ready.
REQ-026 rst asserted mid-scan SHALL drop out_valid without a done pulse.

Configuration
REQ-027 With macro REGFILE_READER_PARITY_EN defined, the block SHALL add output out_par (1 bit), registered in SETUP as the even parity (XOR) of o, and reset to 0.
REQ-028 Without REGFILE_READER_PARITY_EN, out_par SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-029 State encoding (IDLE/SETUP/SEND) and the default widths SHALL live in a shared package, regfile_pkg, reused by the register-file blocks.
REQ-030 The block SHALL be a single module with no sub-module, and the parity XOR SHALL be inline.

Verification
REQ-031 With regfile preloaded 1,2,4,8 (w1=2,w2=8), start pulse, out_ready=1: the bench SHALL see words (addr,data) = (0,1),(1,2),(2,4),(3,8) on consecutive SEND cycles, then done pulse at cycle 8.
REQ-032 Same preload, out_ready=0 for 5 cycles at addr 1: out_data SHALL stay 2 with out_valid=1 throughout, and the scan SHALL resume on ready.
REQ-033 abort in SEND of addr 2 with out_ready=1: no further words, busy=0 next cycle, and no done pulse.
REQ-034 start re-pulsed during a scan: the bench SHALL see no restart, exactly 4 words, and one done.
REQ-035 rst=1 in SETUP of addr 1: the bench SHALL see all outputs 0 next cycle; a later start SHALL scan from addr 0.
REQ-036 With REGFILE_READER_PARITY_EN and a register value of 8'h07: out_par SHALL be 1; for 8'h03 it SHALL be 0.
